// File: rtl/fifo_push_arb_pkg.sv
// Shared definitions for the FIFO push arbiter and the FIFO it feeds:
// arbiter state encoding, FIFO geometry and a modular-index helper.
package fifo_push_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int FIFO_DEPTH = 8;
    localparam int FIFO_CNT_W = 4;

    // (a + b) mod n, used for round-robin pointer arithmetic.
    function automatic int wrap_add(input int a, input int b, input int n);
        return (a + b) % n;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request at or after rr_ptr, wrapping.
// Purely combinational; gnt is all-zero when req is all-zero.
module rr_pick
    import fifo_push_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] rr_ptr,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] idx
);

    localparam int IW = $clog2(NREQ);

    int   j;
    logic found;

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = wrap_add(int'(rr_ptr), k, NREQ);
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/fifo_push_arb.sv
// Burst arbiter sharing one FIFO write port among NREQ producers:
// round-robin grant, up to MAX_BURST pushes per grant, stalls on fifo_full.
module fifo_push_arb
    import fifo_push_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*DW-1:0]      req_data,
    input  logic                    fifo_full,
    output logic [NREQ-1:0]         gnt,
    output logic                    push,
    output logic [DW-1:0]           fifo_in,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    busy
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_t      state, state_nxt;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   pick_idx;
    logic [NREQ-1:0] pick_gnt;
    logic [CW-1:0]   burst_cnt;
    logic            owner_req;
    logic            last_push;
    logic            burst_end;

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .gnt    (pick_gnt),
        .idx    (pick_idx)
    );

    assign owner_req = req[owner];
    assign last_push = push && (burst_cnt == CW'(MAX_BURST - 1));
    // A dropped request ends the burst even while the FIFO is stalling it.
    assign burst_end = !owner_req || last_push;

    // NOTE: sequential state uses non-blocking assignments; async reset forces IDLE immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req)     state_nxt = BURST;
            BURST:   if (burst_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state == BURST);
        push    = busy && owner_req && !fifo_full;
        fifo_in = busy ? req_data[int'(owner)*DW +: DW] : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt       <= '0;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else if (state == IDLE) begin
            if (|req) begin
                gnt       <= pick_gnt;
                owner     <= pick_idx;
                burst_cnt <= '0;
            end
        end else if (burst_end) begin
            gnt       <= '0;
            rr_ptr    <= IW'(wrap_add(int'(owner), 1, NREQ));
            burst_cnt <= '0;
        end else if (push) begin
            burst_cnt <= burst_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_fifo_push_arb.sv
// Directed bench for fifo_push_arb: grant timing, round-robin order, stalls,
// early release, async reset and an end-to-end run into an 8-entry FIFO model.
module tb_fifo_push_arb;
    import fifo_push_arb_pkg::*;

    localparam int NW = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        fifo_full;
    logic [3:0]  gnt;
    logic        push;
    logic [7:0]  fifo_in;
    logic [1:0]  owner;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    fifo_push_arb #(.NREQ(4), .DW(8), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .fifo_full (fifo_full),
        .gnt       (gnt),
        .push      (push),
        .fifo_in   (fifo_in),
        .owner     (owner),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [3:0] r, input logic f);
        req       = r;
        fifo_full = f;
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    function automatic int dat(input int i);
        return 8'hA0 + 8'h11 * i;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int          sent [4];
    int          rcvd [4];
    logic [7:0]  q [$];
    logic [7:0]  w;
    logic [FIFO_CNT_W-1:0] fill;
    logic        saw_full;
    logic        all_done;

    initial begin
        req       = 4'b0000;
        fifo_full = 1'b0;
        req_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};

        // Reset state
        #3;
        check("rst_gnt",   32'(gnt),           0);
        check("rst_push",  32'(push),          0);
        check("rst_busy",  32'(busy),          0);
        check("rst_owner", 32'(owner),         0);
        check("rst_ptr",   32'(dut.rr_ptr),    0);
        check("rst_cnt",   32'(dut.burst_cnt), 0);
        #4 rst = 1'b1;

        // Single requester: grant, 4 pushes, one bubble, regrant
        drive(4'b0001, 1'b0);
        check("a_idle_gnt",  32'(gnt),  0);
        check("a_idle_push", 32'(push), 0);
        step;
        check("a_gnt",   32'(gnt),   1);
        check("a_owner", 32'(owner), 0);
        check("a_busy",  32'(busy),  1);
        for (int p = 0; p < 4; p++) begin
            check("a_push", 32'(push),          1);
            check("a_cnt",  32'(dut.burst_cnt), p);
            check("a_data", 32'(fifo_in),       dat(0));
            step;
        end
        check("a_bub_gnt",  32'(gnt),     0);
        check("a_bub_busy", 32'(busy),    0);
        check("a_bub_push", 32'(push),    0);
        check("a_bub_data", 32'(fifo_in), 0);
        step;
        check("a_regrant", 32'(gnt), 1);
        drive(4'b0000, 1'b0);
        check("a_drop_push", 32'(push), 0);
        step;
        check("a_end_gnt", 32'(gnt),        0);
        check("a_end_ptr", 32'(dut.rr_ptr), 1);

        // All requesting: order 0,1,2,3,0, four pushes each, one bubble between
        do_reset;
        drive(4'b1111, 1'b0);
        for (int g = 0; g < 5; g++) begin
            step;
            check("b_gnt",   32'(gnt),   1 << (g % 4));
            check("b_owner", 32'(owner), g % 4);
            for (int p = 0; p < 4; p++) begin
                check("b_push", 32'(push),    1);
                check("b_data", 32'(fifo_in), dat(g % 4));
                step;
            end
            check("b_bubble", 32'(gnt),  0);
            check("b_bub_bs", 32'(busy), 0);
        end
        drive(4'b0000, 1'b0);

        // FIFO full stalls requester 2 for 3 cycles after its 2nd push
        do_reset;
        drive(4'b0100, 1'b0);
        step;
        check("c_gnt", 32'(gnt), 4);
        for (int p = 0; p < 2; p++) begin
            check("c_push", 32'(push), 1);
            step;
        end
        drive(4'b0100, 1'b1);
        for (int s = 0; s < 3; s++) begin
            check("c_stall_push", 32'(push),          0);
            check("c_stall_cnt",  32'(dut.burst_cnt), 2);
            check("c_stall_gnt",  32'(gnt),           4);
            step;
        end
        drive(4'b0100, 1'b0);
        for (int p = 2; p < 4; p++) begin
            check("c_push2", 32'(push),          1);
            check("c_cnt2",  32'(dut.burst_cnt), p);
            step;
        end
        check("c_end_gnt", 32'(gnt),        0);
        check("c_end_ptr", 32'(dut.rr_ptr), 3);
        drive(4'b0000, 1'b0);

        // Requester 1 drops after one push; then req 0011 goes to 0
        do_reset;
        drive(4'b0010, 1'b0);
        step;
        check("d_gnt",  32'(gnt),  2);
        check("d_push", 32'(push), 1);
        step;
        check("d_cnt", 32'(dut.burst_cnt), 1);
        drive(4'b0000, 1'b0);
        check("d_drop_push", 32'(push), 0);
        step;
        check("d_rel_gnt", 32'(gnt),        0);
        check("d_rel_ptr", 32'(dut.rr_ptr), 2);
        drive(4'b0011, 1'b0);
        step;
        check("d_wrap_gnt", 32'(gnt), 1);
        // Owner drops while FIFO is full: still releases
        drive(4'b0010, 1'b1);
        check("d_full_push", 32'(push), 0);
        step;
        check("d_full_gnt", 32'(gnt),        0);
        check("d_full_ptr", 32'(dut.rr_ptr), 1);
        drive(4'b0010, 1'b0);
        step;
        check("d_next_gnt", 32'(gnt), 2);
        drive(4'b0000, 1'b0);
        step;

        // Asynchronous reset mid-burst
        do_reset;
        drive(4'b0100, 1'b0);
        step;
        check("e_gnt", 32'(gnt), 4);
        step;
        rst = 1'b0;
        #1;
        check("e_rst_gnt",   32'(gnt),           0);
        check("e_rst_push",  32'(push),          0);
        check("e_rst_busy",  32'(busy),          0);
        check("e_rst_owner", 32'(owner),         0);
        check("e_rst_cnt",   32'(dut.burst_cnt), 0);
        req = 4'b1111;
        @(negedge clk);
        rst = 1'b1;
        step;
        check("e_after_gnt", 32'(gnt), 1);
        drive(4'b0000, 1'b0);
        step;
        step;

        // End-to-end into an 8-entry FIFO model with a slow consumer
        do_reset;
        for (int i = 0; i < 4; i++) begin
            sent[i] = 0;
            rcvd[i] = 0;
        end
        saw_full = 1'b0;
        all_done = 1'b0;
        for (int cyc = 0; cyc < 2000 && !all_done; cyc++) begin
            fill = FIFO_CNT_W'(q.size());
            for (int i = 0; i < 4; i++) begin
                req[i]             = (sent[i] < NW);
                req_data[i*8 +: 8] = {2'(i), 6'(sent[i])};
            end
            fifo_full = (int'(fill) == FIFO_DEPTH);
            if (fifo_full) saw_full = 1'b1;
            #1;
            check("f_push_full", 32'(push & fifo_full), 0);
            if (cyc % 3 == 0 && q.size() > 0) begin
                w = q.pop_front();
                check("f_order", 32'(w[5:0]), rcvd[w[7:6]]);
                rcvd[w[7:6]]++;
            end
            if (push) begin
                for (int i = 0; i < 4; i++) begin
                    if (gnt[i] && req[i]) begin
                        check("f_data", 32'(fifo_in), 32'({2'(i), 6'(sent[i])}));
                        q.push_back(fifo_in);
                        sent[i]++;
                    end
                end
            end
            all_done = (q.size() == 0);
            for (int i = 0; i < 4; i++) if (sent[i] < NW) all_done = 1'b0;
            step;
        end
        check("f_done",     32'(all_done), 1);
        check("f_saw_full", 32'(saw_full), 1);
        for (int i = 0; i < 4; i++) check("f_rcvd", rcvd[i], NW);
        req = 4'b0000;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_push_arb.md
FIFO_PUSH_ARB -- requirements
Module: fifo_push_arb

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of producers sharing one FIFO write port.
REQ-002 The block SHALL have parameter DW, default 8, giving the data width.
REQ-003 The block SHALL have parameter MAX_BURST, default 4, giving the maximum pushes per grant.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port req, input, NREQ bits: per-producer push request, level-sensitive.
REQ-007 The block SHALL have port req_data, input, NREQ*DW bits: producer i data in slice [i*DW +: DW].
REQ-008 The block SHALL have port fifo_full, input, 1 bit: full flag from the shared FIFO.
REQ-009 The block SHALL have port gnt, output, NREQ bits: registered one-hot grant, all-zero when idle.
REQ-010 The block SHALL have port push, output, 1 bit: FIFO write enable.
REQ-011 The block SHALL have port fifo_in, output, DW bits: FIFO write data.
REQ-012 The block SHALL have port owner, output, clog2(NREQ) bits: index of the current grantee, registered.
REQ-013 The block SHALL have port busy, output, 1 bit: high in BURST state.

Function
REQ-014 The block SHALL implement a two-state FSM with states IDLE and BURST.
REQ-015 In IDLE with req nonzero, the FSM SHALL pick the first requester at or after rr_ptr (wrapping modulo NREQ), load gnt/owner, clear burst_cnt and enter BURST on the next edge.
REQ-016 In IDLE with req zero, the FSM SHALL remain in IDLE with gnt all-zero.
REQ-017 push SHALL be combinational: busy & req[owner] & !fifo_full.
REQ-018 fifo_in SHALL equal req_data slice [owner] whenever busy, else zero.
REQ-019 A producer's word SHALL be considered accepted exactly in cycles where gnt[i] & req[i] & push are all high; producers SHALL hold data until then.
REQ-020 In BURST with fifo_full high, push SHALL be low, burst_cnt SHALL hold, and the FSM SHALL remain in BURST (stall, no timeout).
REQ-021 Each push SHALL increment burst_cnt (width clog2(MAX_BURST+1)).
REQ-022 The FSM SHALL leave BURST to IDLE when req[owner] is low, or when a push brings burst_cnt to MAX_BURST; gnt SHALL clear on that edge.
REQ-023 On leaving BURST, rr_ptr SHALL become (owner+1) mod NREQ, so the last grantee has lowest priority next.
REQ-024 Exactly one IDLE bubble cycle SHALL separate consecutive grants.
REQ-025 If req[owner] falls and fifo_full is high in the same cycle, the exit rule of REQ-022 SHALL still apply.
REQ-026 Requests from non-owners SHALL have no effect during BURST.

Reset
REQ-027 Asserting rst low SHALL immediately force IDLE, gnt=0, owner=0, rr_ptr=0, burst_cnt=0, busy=0 and push=0, regardless of the clock, including mid-burst.
REQ-028 After rst deasserts, arbitration SHALL begin at requester 0 on the first rising edge.

Structure
REQ-029 The FSM state encoding and the FIFO depth/counter-width constants (depth 8, counter 4 bits) SHALL reside in a shared package used by the FIFO and this block.
REQ-030 Round-robin selection SHALL be a sub-module rr_pick (inputs req and rr_ptr; outputs a one-hot grant and an index), purely combinational.

Verification
REQ-031 Verification SHALL cover: req=4'b0001 held and fifo_full=0 -> gnt=0001 one cycle later, then 4 pushes, then a 1-cycle IDLE, then a regrant of requester 0.
REQ-032 Verification SHALL cover: req=4'b1111 continuously -> grant order 0,1,2,3,0, each burst 4 pushes, one bubble between bursts.
REQ-033 Verification SHALL cover: requester 2 is granted, fifo_full is high for 3 cycles after its 2nd push -> push=0 for those 3 cycles, burst_cnt holds at 2, and burst completes with 2 more pushes.
REQ-034 Verification SHALL cover: requester 1 drops req after 1 push -> next edge gnt=0 and rr_ptr=2; with req=4'b0011 the next grant goes to requester 0.
REQ-035 Verification SHALL cover: rst pulsed low mid-burst between clock edges -> gnt, push and busy fall to 0 immediately, and after release requester 0 wins.
REQ-036 Verification SHALL cover: a connected 8-entry FIFO with 4 producers each sending sequences tagged by producer -> no loss or duplication, per-producer order preserved, and push never high while fifo_full is high.
